reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data width of the shared register.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..16.
REQ-003 clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-006 wdata  input  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-008 grant_id  output  clog2(NREQ)  index of the current or last granted requester.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 q  output  WIDTH  contents of the shared register.

Function
REQ-011 The FSM SHALL have three states, IDLE, LOAD and DONE, and SHALL cycle IDLE->LOAD->DONE->IDLE.
REQ-012 IDLE: at a rising edge with any req bit high, the block SHALL select one winner, register grant_id and the winner's wdata slice, and enter LOAD; with req all zero, it SHALL stay in IDLE.
REQ-013 LOAD: lasts exactly one cycle; internal load is high; q takes the captured data at the edge that leaves LOAD.
REQ-014 DONE: lasts exactly one cycle; ack[grant_id] is high, all other ack bits are low, and req is not sampled.
REQ-015 Latency: req sampled at edge T -> q valid after T+1 -> ack high from T+1 to T+2 -> IDLE after T+2; throughput is one write per 3 cycles.
REQ-016 Handshake: a requester holds req and wdata until it samples ack high, then deasserts req on the next cycle; the arbiter samples req again no earlier than edge T+3.
REQ-017 A grant is committed once LOAD is entered: deasserting req or changing wdata after edge T SHALL NOT alter the write.
REQ-018 A req bit that falls before being sampled in IDLE SHALL produce no write and no ack.
REQ-019 Round-robin: the search starts at (last grant_id + 1) mod NREQ and picks the first set req bit; the pointer advances only on a grant.
REQ-020 With simultaneous requests, exactly one requester is granted per transaction, and no requester waits more than NREQ-1 transactions.
REQ-021 ack SHALL be registered; ack, load and busy SHALL never be asserted for more than one requester or transaction at a time.

Reset
REQ-022 Asserting reset_n low SHALL, at any time including mid-LOAD or mid-DONE, immediately force state=IDLE, q=0, ack=0, busy=0, grant_id=0 and the round-robin pointer so that requester 0 is searched first.
REQ-023 A write interrupted by reset SHALL be discarded; the requester receives no ack.
REQ-024 Release of reset_n is synchronised externally; the first arbitration occurs at the first rising edge after release.

Configuration
REQ-025 Macro REG_ARB_FIXED_PRIO_EN undefined (default): round-robin per REQ-019.
REQ-026 Macro REG_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest-index set req bit wins, the pointer is removed, and REQ-020 fairness no longer applies; all other behaviour is identical.

Structure
REQ-027 A shared package reg_arb_pkg SHALL hold the state enum (IDLE, LOAD, DONE), the default WIDTH and NREQ constants, and the index-width function.
REQ-028 q SHALL be held in one instance of the team's loadable Register sub-module (WIDTH parameter, active-high reset driven by ~reset_n, load driven by the FSM); the arbiter and FSM SHALL be in reg_write_arbiter itself.

Verification (WIDTH=16, NREQ=4)
REQ-029 Reset: assert reset_n low during LOAD of a 0x1234 write -> q=0x0000, ack=0, busy=0 immediately; no ack follows after release.
REQ-030 Single request: req=0010, wdata[1]=0xA5A5 sampled at edge T -> q=0xA5A5 after T+1; ack=0010 for one cycle; grant_id=1.
REQ-031 Contention: req=1111 from reset, each requester drops req after its ack -> grant order 0,1,2,3; writes exactly 3 cycles apart.
REQ-032 Fairness: req0 and req2 re-request continuously -> grants alternate 0,2,0,2; requester 0 never wins twice in a row.
REQ-033 Withdrawal: req3 drops one cycle after being sampled -> write and ack still occur; req3 pulsed high only between two IDLE sampling edges -> no write.
REQ-034 With REG_ARB_FIXED_PRIO_EN: req0 and req3 held continuously -> requester 0 wins every transaction; q always equals wdata[0].

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write arbiter.
// Holds the FSM state enum, default sizes and the index-width helper.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_NREQ  = 4;

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_register.sv
// Loadable register with an asynchronous active-high reset.
// Holds its value unless load is high at a rising clock edge.
module reg_write_arbiter_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates NREQ writers onto one shared register through an IDLE->LOAD->DONE FSM.
// Define REG_ARB_FIXED_PRIO_EN for fixed (lowest index wins) priority instead of round-robin.
//
// Handshake: a requester raises req[i] with wdata slice i stable and holds both until it
// sees ack[i] high; ack[i] is a one-cycle registered pulse, after which req[i] drops.
// The grant and data are captured at the IDLE sampling edge, so later changes are ignored.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter int  NREQ  = DEFAULT_NREQ,
    localparam int IW    = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic [IW-1:0]         grant_id,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output state_t                fsm_state
);

    state_t           state;
    state_t           next_state;
    logic             load;
    logic             any_req;
    logic             grant_now;
    logic [IW-1:0]    winner;
    logic [WIDTH-1:0] data_r;
    logic [NREQ-1:0]  ack_next;

    assign any_req   = |req;
    assign grant_now = (state == IDLE) && any_req;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    // First set request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant_now) begin
            ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_next           = '0;
        ack_next[grant_id] = 1'b1;
    end

    // ack is raised by the LOAD->DONE edge so it is high exactly for the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id <= '0;
            data_r   <= '0;
            ack      <= '0;
        end else begin
            if (grant_now) begin
                grant_id <= winner;
                data_r   <= wdata[int'(winner) * WIDTH +: WIDTH];
            end
            ack <= (state == LOAD) ? ack_next : '0;
        end
    end

    reg_write_arbiter_register #(
        .WIDTH(WIDTH)
    ) u_q_reg (
        .clk (clk),
        .rst (~reset_n),
        .load(load),
        .d   (data_r),
        .q   (q)
    );

endmodule
